// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: ALU operation encoding used by the ALU and its harness.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_SRA  = 4'h2,
    ALU_ADD  = 4'h3,
    ALU_SUB  = 4'h4,
    ALU_AND  = 4'h5,
    ALU_OR   = 4'h6,
    ALU_XOR  = 4'h7,
    ALU_NOR  = 4'h8,
    ALU_SLT  = 4'h9,
    ALU_SLTU = 4'hA
  } aluop_t;

endpackage

// File: rtl/fpga_io_pkg.sv
// FPGA board I/O types: loader FSM states and debounce defaults.
package fpga_io_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } loader_state_t;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 500000;

  // Sign-extend the 17-bit switch field (bit 16 = sign) to a 32-bit operand.
  function automatic logic [31:0] sext_operand(input logic [16:0] sw);
    return {{16{sw[16]}}, sw[15:0]};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, stability counter,
// and a one-cycle pulse on the debounced released->pressed transition.
// level is the debounced button level in the raw polarity (1 = released).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic CLK,
  input  logic nRST,
  input  logic raw_n,
  output logic level,
  output logic press_pulse
);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             pulse_r;
  logic [CNT_W-1:0] cnt_r;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchroniser; resets to the released level so reset never looks like a press.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= raw_n;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter: the debounced level follows only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_r   <= '0;
      level_r <= 1'b1;
      pulse_r <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r   <= '0;
      pulse_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= '0;
      level_r <= sync2_r;
      pulse_r <= ~sync2_r;  // only the move to pressed (0) produces a pulse
    end else begin
      cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      pulse_r <= 1'b0;
    end
  end

  assign level       = level_r;
  assign press_pulse = pulse_r;

endmodule

// File: rtl/alu_input_sequencer.sv
// Press-driven loader for the ALU harness: each debounced load press captures
// A, then B, then the opcode, then shows the result; clr returns to LOAD_A.
module alu_input_sequencer
  import fpga_io_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [16:0] sw_data,
  input  logic        load_n,
  input  logic        clr_n,
  output logic [31:0] portA,
  output logic [31:0] portB,
  output aluop_t      aluop,
  output logic [1:0]  state_o,
  output logic        out_valid
);

  loader_state_t state_r, state_next;
  logic [31:0]   port_a_r, port_a_next;
  logic [31:0]   port_b_r, port_b_next;
  aluop_t        aluop_r, aluop_next;
  logic          out_valid_r;
  logic          load_pulse, clr_pulse;
  logic          load_level, clr_level;
  logic          unused_levels;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_load_db (
    .CLK(CLK), .nRST(nRST), .raw_n(load_n), .level(load_level), .press_pulse(load_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clr_db (
    .CLK(CLK), .nRST(nRST), .raw_n(clr_n), .level(clr_level), .press_pulse(clr_pulse)
  );

  // Debounced levels are not needed here; only the press pulses drive the FSM.
  assign unused_levels = load_level ^ clr_level;

  // State and operand registers; out_valid trails the SHOW state by one cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= LOAD_A;
      port_a_r    <= 32'h0000_0000;
      port_b_r    <= 32'h0000_0000;
      aluop_r     <= aluop_t'(4'h0);
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next;
      port_a_r    <= port_a_next;
      port_b_r    <= port_b_next;
      aluop_r     <= aluop_next;
      out_valid_r <= (state_r == SHOW);
    end
  end

  // Next-state and capture logic; clear has priority over load.
  always_comb begin
    state_next  = state_r;
    port_a_next = port_a_r;
    port_b_next = port_b_r;
    aluop_next  = aluop_r;
    if (clr_pulse) begin
      state_next  = LOAD_A;
      port_a_next = 32'h0000_0000;
      port_b_next = 32'h0000_0000;
      aluop_next  = aluop_t'(4'h0);
    end else if (load_pulse) begin
      case (state_r)
        LOAD_A: begin
          port_a_next = sext_operand(sw_data);
          state_next  = LOAD_B;
        end
        LOAD_B: begin
          port_b_next = sext_operand(sw_data);
          state_next  = LOAD_OP;
        end
        LOAD_OP: begin
          aluop_next = aluop_t'(sw_data[3:0]);
          state_next = SHOW;
        end
        SHOW: begin
          state_next = LOAD_A;
        end
        default: begin
          state_next = LOAD_A;
        end
      endcase
    end else begin
      state_next = state_r;
    end
  end

  assign portA     = port_a_r;
  assign portB     = port_b_r;
  assign aluop     = aluop_r;
  assign state_o   = state_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with a 4-cycle debounce window.
module tb_alu_input_sequencer;

  logic        CLK;
  logic        nRST;
  logic [16:0] sw_data;
  logic        load_n;
  logic        clr_n;
  logic [31:0] portA;
  logic [31:0] portB;
  cpu_types_pkg::aluop_t aluop;
  logic [1:0]  state_o;
  logic        out_valid;

  int n_cmp = 0;
  int n_mis = 0;

  alu_input_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .CLK(CLK), .nRST(nRST), .sw_data(sw_data), .load_n(load_n), .clr_n(clr_n),
    .portA(portA), .portB(portB), .aluop(aluop), .state_o(state_o), .out_valid(out_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, then step just past the edge before driving.
  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press_load(input logic [16:0] sw);
    sw_data = sw;
    load_n  = 1'b0;
    cycles(10);
    load_n  = 1'b1;
    cycles(10);
    @(negedge CLK);
  endtask

  task automatic press_clr();
    clr_n = 1'b0;
    cycles(10);
    clr_n = 1'b1;
    cycles(10);
    @(negedge CLK);
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op, input logic ov);
    check_val({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
    check_val({tag, ".portA"}, portA, a);
    check_val({tag, ".portB"}, portB, b);
    check_val({tag, ".aluop"}, {28'd0, aluop}, {28'd0, op});
    check_val({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ov});
  endtask

  int          n_state_chg;
  int          n_a_chg;
  logic [1:0]  prev_state;
  logic [31:0] prev_a;

  initial begin
    nRST    = 1'b0;
    sw_data = 17'h0_0000;
    load_n  = 1'b1;
    clr_n   = 1'b1;
    cycles(3);
    @(negedge CLK);
    check_all("reset", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);
    nRST = 1'b1;
    cycles(3);

    // Full sequence A=5, B=3, op=ADD, then wrap back to LOAD_A
    press_load(17'h0_0005);
    check_all("seqA", 2'd1, 32'h5, 32'h0, 4'h0, 1'b0);
    press_load(17'h0_0003);
    check_all("seqB", 2'd2, 32'h5, 32'h3, 4'h0, 1'b0);
    press_load(17'h0_0003);
    check_all("seqOP", 2'd3, 32'h5, 32'h3, 4'h3, 1'b1);
    press_load(17'h1_FFFF);
    check_all("seqWrap", 2'd0, 32'h5, 32'h3, 4'h3, 1'b0);

    // Sign extension
    press_load(17'h1_FFFE);
    check_val("sextNeg", portA, 32'hFFFF_FFFE);
    press_clr();
    check_all("clrB", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);
    press_load(17'h0_8000);
    check_val("sextPos", portA, 32'h0000_8000);
    check_val("sextState", {30'd0, state_o}, 32'd1);

    // Simultaneous clr and load in LOAD_B: clear wins
    sw_data = 17'h0_0077;
    load_n  = 1'b0;
    clr_n   = 1'b0;
    cycles(10);
    load_n  = 1'b1;
    clr_n   = 1'b1;
    cycles(10);
    @(negedge CLK);
    check_all("simul", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Bounce rejection: 3 low, 2 high, 3 low
    sw_data = 17'h0_0005;
    load_n = 1'b0; cycles(3);
    load_n = 1'b1; cycles(2);
    load_n = 1'b0; cycles(3);
    load_n = 1'b1; cycles(10);
    @(negedge CLK);
    check_all("bounce", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);
    press_load(17'h0_0005);
    check_all("bounceHeld", 2'd1, 32'h5, 32'h0, 4'h0, 1'b0);

    // Clear from LOAD_OP
    press_load(17'h0_0003);
    check_all("preClr", 2'd2, 32'h5, 32'h3, 4'h0, 1'b0);
    press_clr();
    check_all("clrOP", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Clear from SHOW: out_valid must drop
    press_load(17'h0_0001);
    press_load(17'h0_0002);
    press_load(17'h0_0007);
    check_all("preClrShow", 2'd3, 32'h1, 32'h2, 4'h7, 1'b1);
    press_clr();
    check_all("clrShow", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Async reset mid-press in LOAD_B
    press_load(17'h0_0007);
    sw_data = 17'h0_0009;
    load_n  = 1'b0;
    cycles(4);
    nRST = 1'b0;
    #1;
    check_all("asyncRst", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);
    cycles(2);
    nRST = 1'b1;
    cycles(3);
    @(negedge CLK);
    check_val("rstNoAdv", {30'd0, state_o}, 32'd0);
    cycles(7);
    @(negedge CLK);
    check_val("rstReheld", {30'd0, state_o}, 32'd1);
    check_val("rstReheldA", portA, 32'h9);
    load_n = 1'b1;
    cycles(10);

    // Long hold: exactly one transition in 100 cycles
    sw_data     = 17'h0_0042;
    n_state_chg = 0;
    n_a_chg     = 0;
    @(negedge CLK);
    prev_state  = state_o;
    prev_a      = portA;
    load_n      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (state_o != prev_state) n_state_chg++;
      if (portA != prev_a) n_a_chg++;
      prev_state = state_o;
      prev_a     = portA;
    end
    load_n = 1'b1;
    cycles(10);
    @(negedge CLK);
    check_val("holdTrans", n_state_chg, 32'd1);
    check_val("holdAStable", n_a_chg, 32'd0);
    check_all("holdEnd", 2'd2, 32'h9, 32'h42, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
